intc: RTL
=========

INTC -- requirements
Module: intc

Interface
REQ-001 SHALL declare parameter none; channel count fixed at CPU_IRQ_CH (8), bus data width 32.
REQ-002 SHALL have ports: clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: cs_  input  1  chip select, active low.
REQ-005 SHALL have ports: as_  input  1  address strobe, active low.
REQ-006 SHALL have ports: rw  input  1  1=read, 0=write.
REQ-007 SHALL have ports: addr  input  2  register index.
REQ-008 SHALL have ports: wr_data  input  32  write data.
REQ-009 SHALL have ports: rd_data  output  32  read data.
REQ-010 SHALL have ports: rdy_  output  1  access complete, active low.
REQ-011 SHALL have ports: src  input  8  asynchronous peripheral interrupt sources, active high.
REQ-012 SHALL have ports: irq  output  8  interrupt requests to CPU irq input, active high.

Function
REQ-013 SHALL map registers: 0=PEND (R / W1C), 1=MODE (RW, bit=1 rising-edge, 0=level), 2=ENABLE (RW), 3=RAW (RO, synchronized src); bits [31:8] read 0, writes ignored.
REQ-014 SHALL respond to an access (cs_=0 and as_=0 at a clock edge) by driving rdy_=0 for exactly the following cycle, with rd_data valid in that cycle for reads; rdy_=1 and rd_data=0 otherwise.
REQ-015 SHALL accept back-to-back accesses on consecutive cycles, each answered one cycle later.
REQ-016 SHALL perform edge detection by comparing the synchronized source with its value registered one cycle earlier; rising edge sets PEND bit.
REQ-017 SHALL, in level mode, load PEND bit from the synchronized source every cycle; W1C writes to level-mode bits have no effect.
REQ-018 SHALL, in edge mode, hold PEND bit until cleared by write of 1 to that bit of register 0.
REQ-019 SHALL give set priority over clear when an edge and a W1C to the same bit fall in the same cycle (bit stays 1).
REQ-020 SHALL drive irq = PEND & ENABLE combinationally from registers.
REQ-021 SHALL, when a MODE bit changes edge->level, reload PEND from the synchronized level next cycle; level->edge keeps current PEND value and records no spurious edge.
REQ-022 SHALL not set PEND for a bit whose ENABLE is 0 in a way that differs from enabled bits (masking only affects irq).
REQ-023 SHALL latency (with REQ-027 macro): src rising before edge k -> PEND/irq high after edge k+2.

Reset
REQ-024 SHALL on reset=1, immediately and independent of clk, clear PEND, ENABLE, RAW, synchronizer and edge-history flops to 0, set MODE to 8'hFF (all edge), rdy_=1, rd_data=0, irq=0.
REQ-025 SHALL abort an access in flight at reset; no rdy_ pulse is issued for it after release.
REQ-026 SHALL treat a src already high at reset release as no edge (history resets to 0 but first edge needs sync to settle; edge counted once only).

Configuration
REQ-027 SHALL compile a two-flop src synchronizer when INTC_SYNC_EN is defined (latency per REQ-023).
REQ-028 SHALL, without INTC_SYNC_EN, use a single sampling flop: src rising before edge k -> irq high after edge k+1; all other behaviour identical.

Verification
REQ-029 SHALL check edge latch: MODE=FF, ENABLE=01, pulse src[0] one cycle -> irq=01 after 3 edges (2 without macro), stays 01 until write PEND=01, then irq=00 next cycle.
REQ-030 SHALL check level: MODE=FE, ENABLE=01, src[0] high 5 cycles -> irq[0] high 5 cycles delayed by latency; write PEND=01 mid-way -> no change.
REQ-031 SHALL check collision: edge on src[3] in same cycle as W1C 08 -> PEND reads 08.
REQ-032 SHALL check masking: ENABLE=00, edge on src[5] -> irq=00, PEND reads 20; write ENABLE=20 -> irq=20 next cycle.
REQ-033 SHALL check bus: read addr 1 after reset -> rdy_=0 one cycle later with rd_data=000000FF; two consecutive reads -> two consecutive rdy_ pulses.
REQ-034 SHALL check reset mid-access: assert reset during as_=0 -> rdy_ stays 1, all registers at REQ-024 values.

Source files
------------

// File: rtl/intc.sv
// ---------------------------------------------------------------------------
// intc -- 8-channel interrupt controller with a small register bus.
//
// Collects CPU_IRQ_CH (8) asynchronous, active-high peripheral interrupt
// sources. Each channel is individually programmable as rising-edge
// (latched until software clears it) or level (follows the synchronized
// source). Each channel is also individually enabled. The CPU sees
// irq = PEND & ENABLE.
//
// Register map (addr, 32-bit data, bits [31:8] read 0 and ignore writes):
//   0 PEND   R / W1C  pending bits (W1C only affects edge-mode bits)
//   1 MODE   RW       1 = rising-edge, 0 = level (resets to 8'hFF)
//   2 ENABLE RW       per-channel irq enable      (resets to 8'h00)
//   3 RAW    RO       synchronized source value
//
// Bus handshake: an access is cs_=0 and as_=0 at a rising clk edge. The
// cycle after the access rdy_ is 0 and, for reads, rd_data carries the
// register value. Otherwise rdy_=1 and rd_data=0. Back-to-back accesses on
// consecutive cycles are each answered one cycle later.
//
// Configuration macro: INTC_SYNC_EN
//   defined   -> two-flop src synchronizer (src rising before edge k gives
//                PEND/irq high after edge k+2)
//   undefined -> single sampling flop (irq high after edge k+1)
//
// Ports:
//   clk      in   1   single clock, all state on the rising edge
//   reset    in   1   asynchronous active-high reset
//   cs_      in   1   chip select, active low
//   as_      in   1   address strobe, active low
//   rw       in   1   1 = read, 0 = write
//   addr     in   2   register index
//   wr_data  in  32   write data
//   rd_data  out 32   read data (registered)
//   rdy_     out  1   access complete, active low (registered)
//   src      in   8   peripheral interrupt sources, asynchronous
//   irq      out  8   interrupt requests to the CPU
// ---------------------------------------------------------------------------
module intc (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  input  logic [7:0]  src,
  output logic [7:0]  irq
);

  localparam int CPU_IRQ_CH = 8;
  localparam int DATA_W     = 32;

  localparam logic [1:0] ADDR_PEND   = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_ENABLE = 2'd2;
  localparam logic [1:0] ADDR_RAW    = 2'd3;

`ifdef INTC_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic [CPU_IRQ_CH-1:0] raw_reg;      // synchronized source (RAW register)
  logic [CPU_IRQ_CH-1:0] hist_reg;     // raw_reg one cycle earlier
  logic [CPU_IRQ_CH-1:0] pend_reg;
  logic [CPU_IRQ_CH-1:0] pend_next;
  logic [CPU_IRQ_CH-1:0] mode_reg;
  logic [CPU_IRQ_CH-1:0] enable_reg;
  logic [CPU_IRQ_CH-1:0] rise;
  logic [CPU_IRQ_CH-1:0] w1c;

  // Shift register of ones filled after reset release. Its top bit marks the
  // point where hist_reg holds a real sample of src rather than its reset
  // value, so a source already high at reset release is not seen as an edge.
  logic [SYNC_STAGES:0]  prime_reg;
  logic                  hist_valid;

  logic                  access;
  logic                  wr_en;
  logic                  rdy_reg;
  logic [DATA_W-1:0]     rd_data_reg;
  logic [DATA_W-1:0]     rd_mux;

  // Upper write-data bits have no storage behind them.
  logic                  unused_wr_data;
  assign unused_wr_data = ^wr_data[DATA_W-1:CPU_IRQ_CH];

  // -------------------------------------------------------------------------
  // Source synchronizer
  // -------------------------------------------------------------------------
`ifdef INTC_SYNC_EN
  logic [CPU_IRQ_CH-1:0] meta_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= '0;
      raw_reg  <= '0;
    end else begin
      meta_reg <= src;
      raw_reg  <= meta_reg;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_reg <= '0;
    end else begin
      raw_reg <= src;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Edge history and priming
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg  <= '0;
      prime_reg <= '0;
    end else begin
      // History tracks raw_reg in every mode, so switching level->edge
      // never manufactures an edge from stale history.
      hist_reg  <= raw_reg;
      prime_reg <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign hist_valid = prime_reg[SYNC_STAGES];
  assign rise       = hist_valid ? (raw_reg & ~hist_reg) : '0;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  assign access = ~cs_ & ~as_;
  assign wr_en  = access & ~rw;
  assign w1c    = (wr_en && (addr == ADDR_PEND)) ? wr_data[CPU_IRQ_CH-1:0] : '0;

  // -------------------------------------------------------------------------
  // Per-channel pending logic
  //   edge mode : set on a rising edge, held until W1C; set wins over clear
  //   level mode: follows the synchronized source every cycle, W1C ignored
  // Enable plays no part here; it only masks irq.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CPU_IRQ_CH; gi++) begin : g_pend
      assign pend_next[gi] = mode_reg[gi]
                           ? (rise[gi] | (pend_reg[gi] & ~w1c[gi]))
                           : raw_reg[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control / status registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg   <= '0;
      mode_reg   <= '1;
      enable_reg <= '0;
    end else begin
      // pend_next is computed with the MODE value in force before this
      // edge; a MODE write takes effect from the next cycle on.
      pend_reg <= pend_next;
      if (wr_en && (addr == ADDR_MODE)) begin
        mode_reg <= wr_data[CPU_IRQ_CH-1:0];
      end
      if (wr_en && (addr == ADDR_ENABLE)) begin
        enable_reg <= wr_data[CPU_IRQ_CH-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read mux and registered response
  // -------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_PEND:   rd_mux = {{(DATA_W-CPU_IRQ_CH){1'b0}}, pend_reg};
      ADDR_MODE:   rd_mux = {{(DATA_W-CPU_IRQ_CH){1'b0}}, mode_reg};
      ADDR_ENABLE: rd_mux = {{(DATA_W-CPU_IRQ_CH){1'b0}}, enable_reg};
      ADDR_RAW:    rd_mux = {{(DATA_W-CPU_IRQ_CH){1'b0}}, raw_reg};
      default:     rd_mux = '0;
    endcase
  end

  // An access sampled before reset is simply lost: reset forces rdy_reg
  // high and nothing remembers the access across release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_reg     <= 1'b1;
      rd_data_reg <= '0;
    end else begin
      rdy_reg     <= ~access;
      rd_data_reg <= (access && rw) ? rd_mux : '0;
    end
  end

  assign rdy_    = rdy_reg;
  assign rd_data = rd_data_reg;
  assign irq     = pend_reg & enable_reg;

endmodule
